msi_cache_ctrl: RTL and testbench

- Clocked, parametrised per-processor MSI snooping cache controller for the shared-bus multiprocessor practice.
- Direct-mapped, NUM_LINES single-word lines, with a processor valid/ready port and an arbitrated bus request port.
- Has an always-active snoop port and a flush port for owner data supply.
- Adds over the step-driven controller: real clock/reset, arbitration handshake, write-upgrade, and snoop/miss race handling.

---
 rtl/msi_pkg.sv | 26 ++
 rtl/msi_cache_ctrl_if.sv | 47 ++++
 rtl/msi_line_array.sv | 57 +++++
 rtl/msi_cache_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_msi_cache_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/msi_pkg.sv
// rtl/msi_pkg.sv - shared line-state, bus-message and FSM encodings for the MSI cache controller
package msi_pkg;

    typedef enum logic [1:0] {
        LS_I = 2'b00,
        LS_S = 2'b01,
        LS_M = 2'b10
    } line_state_t;

    typedef enum logic [1:0] {
        BUS_NONE   = 2'b00,
        BUS_RDMISS = 2'b01,
        BUS_INVAL  = 2'b10,
        BUS_WB     = 2'b11
    } bus_msg_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        ARB_WB    = 3'd2,
        ARB_MISS  = 3'd3,
        WAIT_FILL = 3'd4,
        RESP      = 3'd5
    } fsm_state_t;

endpackage

// File: rtl/msi_cache_ctrl_if.sv
// rtl/msi_cache_ctrl_if.sv - processor, bus, snoop and flush signals of one MSI cache controller
interface msi_cache_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 4
);
    logic              cpu_req_valid;
    logic              cpu_req_we;
    logic [ADDR_W-1:0] cpu_req_addr;
    logic [DATA_W-1:0] cpu_req_wdata;
    logic              cpu_req_ready;
    logic              cpu_resp_valid;
    logic [DATA_W-1:0] cpu_resp_rdata;
    logic              cpu_resp_hit;
    logic              bus_req;
    logic              bus_gnt;
    logic              bus_out_valid;
    logic [1:0]        bus_out_type;
    logic [ADDR_W-1:0] bus_out_addr;
    logic [DATA_W-1:0] bus_out_data;
    logic              fill_valid;
    logic [DATA_W-1:0] fill_data;
    logic              snp_valid;
    logic [1:0]        snp_type;
    logic [ADDR_W-1:0] snp_addr;
    logic [1:0]        snp_src;
    logic              flush_valid;
    logic [ADDR_W-1:0] flush_addr;
    logic [DATA_W-1:0] flush_data;

    modport slave (
        input  cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata,
        output cpu_req_ready, cpu_resp_valid, cpu_resp_rdata, cpu_resp_hit,
        output bus_req, bus_out_valid, bus_out_type, bus_out_addr, bus_out_data,
        input  bus_gnt, fill_valid, fill_data,
        input  snp_valid, snp_type, snp_addr, snp_src,
        output flush_valid, flush_addr, flush_data
    );

    modport master (
        output cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata,
        input  cpu_req_ready, cpu_resp_valid, cpu_resp_rdata, cpu_resp_hit,
        input  bus_req, bus_out_valid, bus_out_type, bus_out_addr, bus_out_data,
        output bus_gnt, fill_valid, fill_data,
        output snp_valid, snp_type, snp_addr, snp_src,
        input  flush_valid, flush_addr, flush_data
    );
endinterface

// File: rtl/msi_line_array.sv
// rtl/msi_line_array.sv - direct-mapped line storage with an FSM port and a snoop state port
module msi_line_array
    import msi_pkg::*;
#(
    parameter int NUM_LINES = 4,
    parameter int INDEX_W   = 2,
    parameter int TAG_W     = 3,
    parameter int DATA_W    = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [INDEX_W-1:0] i_fsm_idx,
    output line_state_t        o_fsm_state,
    output logic [TAG_W-1:0]   o_fsm_tag,
    output logic [DATA_W-1:0]  o_fsm_data,
    input  logic               i_fsm_we,
    input  line_state_t        i_fsm_wstate,
    input  logic [TAG_W-1:0]   i_fsm_wtag,
    input  logic [DATA_W-1:0]  i_fsm_wdata,
    input  logic [INDEX_W-1:0] i_snp_idx,
    output line_state_t        o_snp_state,
    output logic [TAG_W-1:0]   o_snp_tag,
    output logic [DATA_W-1:0]  o_snp_data,
    input  logic               i_snp_we,
    input  line_state_t        i_snp_wstate
);
    line_state_t       r_state [NUM_LINES];
    logic [TAG_W-1:0]  r_tag   [NUM_LINES];
    logic [DATA_W-1:0] r_data  [NUM_LINES];

    assign o_fsm_state = r_state[i_fsm_idx];
    assign o_fsm_tag   = r_tag[i_fsm_idx];
    assign o_fsm_data  = r_data[i_fsm_idx];
    assign o_snp_state = r_state[i_snp_idx];
    assign o_snp_tag   = r_tag[i_snp_idx];
    assign o_snp_data  = r_data[i_snp_idx];

    // Snoop state update first; an FSM install to the same index replaces the whole line after it
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                r_state[i] <= LS_I;
                r_tag[i]   <= '0;
                r_data[i]  <= '0;
            end
        end else begin
            if (i_snp_we) begin
                r_state[i_snp_idx] <= i_snp_wstate;
            end
            if (i_fsm_we) begin
                r_state[i_fsm_idx] <= i_fsm_wstate;
                r_tag[i_fsm_idx]   <= i_fsm_wtag;
                r_data[i_fsm_idx]  <= i_fsm_wdata;
            end
        end
    end
endmodule

// File: rtl/msi_cache_ctrl.sv
// rtl/msi_cache_ctrl.sv - clocked MSI snooping cache controller with arbitrated bus port
module msi_cache_ctrl
    import msi_pkg::*;
#(
    parameter logic [1:0] PROC_ID   = 2'd0,
    parameter int         NUM_LINES = 4,
    parameter int         ADDR_W    = 5,
    parameter int         DATA_W    = 4
) (
    input  logic            clock,
    input  logic            reset,
    msi_cache_ctrl_if.slave cc
);
    localparam int INDEX_W = $clog2(NUM_LINES);
    localparam int TAG_W   = ADDR_W - INDEX_W;

    fsm_state_t        r_fsm_state, w_next_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic              r_gnt_seen, w_gnt_seen_n;
    logic [DATA_W-1:0] r_resp_data, w_resp_data_n;
    logic              r_resp_hit, w_resp_hit_n, w_resp_load;
    logic              r_flush_valid, w_flush;
    logic [ADDR_W-1:0] r_flush_addr;
    logic [DATA_W-1:0] r_flush_data;

    line_state_t       w_line_state, w_snp_state, w_fsm_wstate, w_snp_wstate;
    logic [TAG_W-1:0]  w_line_tag, w_snp_tag;
    logic [DATA_W-1:0] w_line_data, w_snp_data, w_fsm_wdata;
    logic              w_fsm_we, w_snp_we, w_lookup_hit, w_snp_match;
    logic              w_bus_req, w_out_valid;
    bus_msg_t          w_out_type;
    logic [ADDR_W-1:0] w_out_addr;
    logic [DATA_W-1:0] w_out_data;

    wire [INDEX_W-1:0] w_idx     = r_addr[INDEX_W-1:0];
    wire [TAG_W-1:0]   w_tag     = r_addr[ADDR_W-1:INDEX_W];
    wire [INDEX_W-1:0] w_snp_idx = cc.snp_addr[INDEX_W-1:0];
    wire [TAG_W-1:0]   w_snp_adr_tag = cc.snp_addr[ADDR_W-1:INDEX_W];

    msi_line_array #(
        .NUM_LINES(NUM_LINES), .INDEX_W(INDEX_W), .TAG_W(TAG_W), .DATA_W(DATA_W)
    ) u_lines (
        .clock(clock), .reset(reset),
        .i_fsm_idx(w_idx), .o_fsm_state(w_line_state), .o_fsm_tag(w_line_tag), .o_fsm_data(w_line_data),
        .i_fsm_we(w_fsm_we), .i_fsm_wstate(w_fsm_wstate), .i_fsm_wtag(w_tag), .i_fsm_wdata(w_fsm_wdata),
        .i_snp_idx(w_snp_idx), .o_snp_state(w_snp_state), .o_snp_tag(w_snp_tag), .o_snp_data(w_snp_data),
        .i_snp_we(w_snp_we), .i_snp_wstate(w_snp_wstate)
    );

    assign w_lookup_hit = (w_line_state != LS_I) && (w_line_tag == w_tag);
    assign w_snp_match  = cc.snp_valid && (cc.snp_src != PROC_ID) &&
                          (w_snp_state != LS_I) && (w_snp_tag == w_snp_adr_tag);

    // Snoop reaction: demote or invalidate a matching line, owner data flushed the next cycle
    always_comb begin
        w_snp_we     = 1'b0;
        w_snp_wstate = LS_I;
        w_flush      = 1'b0;
        if (w_snp_match) begin
            if (cc.snp_type == BUS_RDMISS && w_snp_state == LS_M) begin
                w_snp_we     = 1'b1;
                w_snp_wstate = LS_S;
                w_flush      = 1'b1;
            end else if (cc.snp_type == BUS_INVAL) begin
                w_snp_we     = 1'b1;
                w_snp_wstate = LS_I;
                w_flush      = (w_snp_state == LS_M);
            end
        end
    end

    // Next-state, bus message and line-install decode; each grant carries one message the cycle after
    always_comb begin
        w_next_state  = r_fsm_state;
        w_gnt_seen_n  = r_gnt_seen;
        w_resp_load   = 1'b0;
        w_resp_data_n = r_resp_data;
        w_resp_hit_n  = r_resp_hit;
        w_fsm_we      = 1'b0;
        w_fsm_wstate  = LS_I;
        w_fsm_wdata   = r_wdata;
        w_bus_req     = 1'b0;
        w_out_valid   = 1'b0;
        w_out_type    = BUS_NONE;
        w_out_addr    = '0;
        w_out_data    = '0;
        case (r_fsm_state)
            IDLE: if (cc.cpu_req_valid) w_next_state = LOOKUP;
            LOOKUP: begin
                if (w_lookup_hit && !r_we) begin
                    w_resp_load   = 1'b1;
                    w_resp_data_n = w_line_data;
                    w_resp_hit_n  = 1'b1;
                    w_next_state  = RESP;
                end else if (w_lookup_hit && w_line_state == LS_M) begin
                    w_fsm_we      = 1'b1;
                    w_fsm_wstate  = LS_M;
                    w_resp_load   = 1'b1;
                    w_resp_data_n = r_wdata;
                    w_resp_hit_n  = 1'b1;
                    w_next_state  = RESP;
                end else if (!w_lookup_hit && w_line_state == LS_M) begin
                    w_next_state = ARB_WB;
                end else begin
                    w_next_state = ARB_MISS;
                end
            end
            ARB_WB: begin
                if (!r_gnt_seen) begin
                    w_bus_req = 1'b1;
                    if (cc.bus_gnt) w_gnt_seen_n = 1'b1;
                end else begin
                    // Victim may have been snooped away while waiting; then the slot goes unused
                    w_gnt_seen_n = 1'b0;
                    if (w_line_state == LS_M) begin
                        w_out_valid = 1'b1;
                        w_out_type  = BUS_WB;
                        w_out_addr  = {w_line_tag, w_idx};
                        w_out_data  = w_line_data;
                    end
                    w_next_state = ARB_MISS;
                end
            end
            ARB_MISS: begin
                if (!r_gnt_seen) begin
                    w_bus_req = 1'b1;
                    if (cc.bus_gnt) w_gnt_seen_n = 1'b1;
                end else begin
                    w_gnt_seen_n = 1'b0;
                    w_out_valid  = 1'b1;
                    w_out_addr   = r_addr;
                    if (r_we) begin
                        w_out_type    = BUS_INVAL;
                        w_fsm_we      = 1'b1;
                        w_fsm_wstate  = LS_M;
                        w_resp_load   = 1'b1;
                        w_resp_data_n = r_wdata;
                        w_resp_hit_n  = 1'b0;
                        w_next_state  = RESP;
                    end else begin
                        w_out_type   = BUS_RDMISS;
                        w_next_state = WAIT_FILL;
                    end
                end
            end
            WAIT_FILL: begin
                if (cc.fill_valid) begin
                    w_fsm_we      = 1'b1;
                    w_fsm_wstate  = LS_S;
                    w_fsm_wdata   = cc.fill_data;
                    w_resp_load   = 1'b1;
                    w_resp_data_n = cc.fill_data;
                    w_resp_hit_n  = 1'b0;
                    w_next_state  = RESP;
                end
            end
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) r_fsm_state <= IDLE;
        else       r_fsm_state <= w_next_state;
    end

    // Request latch, grant flag, response and flush registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_addr        <= '0;
            r_we          <= 1'b0;
            r_wdata       <= '0;
            r_gnt_seen    <= 1'b0;
            r_resp_data   <= '0;
            r_resp_hit    <= 1'b0;
            r_flush_valid <= 1'b0;
            r_flush_addr  <= '0;
            r_flush_data  <= '0;
        end else begin
            if (r_fsm_state == IDLE && cc.cpu_req_valid) begin
                r_addr  <= cc.cpu_req_addr;
                r_we    <= cc.cpu_req_we;
                r_wdata <= cc.cpu_req_wdata;
            end
            r_gnt_seen <= w_gnt_seen_n;
            if (w_resp_load) begin
                r_resp_data <= w_resp_data_n;
                r_resp_hit  <= w_resp_hit_n;
            end
            r_flush_valid <= w_flush;
            if (w_flush) begin
                r_flush_addr <= cc.snp_addr;
                r_flush_data <= w_snp_data;
            end
        end
    end

    assign cc.cpu_req_ready  = (r_fsm_state == IDLE) && !reset;
    assign cc.cpu_resp_valid = (r_fsm_state == RESP);
    assign cc.cpu_resp_rdata = (r_fsm_state == RESP) ? r_resp_data : '0;
    assign cc.cpu_resp_hit   = (r_fsm_state == RESP) && r_resp_hit;
    assign cc.bus_req        = w_bus_req;
    assign cc.bus_out_valid  = w_out_valid;
    assign cc.bus_out_type   = w_out_type;
    assign cc.bus_out_addr   = w_out_addr;
    assign cc.bus_out_data   = w_out_data;
    assign cc.flush_valid    = r_flush_valid;
    assign cc.flush_addr     = r_flush_valid ? r_flush_addr : '0;
    assign cc.flush_data     = r_flush_valid ? r_flush_data : '0;
endmodule

// File: tb/tb_msi_cache_ctrl.sv
// tb/tb_msi_cache_ctrl.sv - scoreboard bench for msi_cache_ctrl against a cache-contents reference model
module tb_msi_cache_ctrl;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 4;
    localparam int NLINES = 4;
    localparam int T_RDMISS = 1, T_INVAL = 2, T_WB = 3;
    localparam int ST_I = 0, ST_S = 1, ST_M = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;

    msi_cache_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) cc();

    msi_cache_ctrl #(.PROC_ID(2'd0), .NUM_LINES(NLINES), .ADDR_W(ADDR_W), .DATA_W(DATA_W))
        dut (.clock(clock), .reset(reset), .cc(cc.slave));

    always #5 clock = ~clock;

    typedef struct { int data; int hit; int lat; } resp_t;
    typedef struct { int typ; int addr; int data; } msg_t;
    typedef struct { int addr; int data; int cyc; } flush_t;

    resp_t  resp_q[$];
    msg_t   bus_q[$];
    flush_t flush_q[$];

    int m_state [NLINES];
    int m_tag   [NLINES];
    int m_data  [NLINES];

    int n_pass = 0, n_total = 0;
    int cyc = 0, acc_cyc = 0, n_grants = 0;
    int junk_req = 0, junk_done = 0;
    bit hold_gnt = 1'b0;
    logic [DATA_W-1:0] next_fill = '0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference model: what each cache slot holds and what the bus must see for one request
    task automatic model_req(input int we, input int addr, input int wdata, input int fill, output int nmsg);
        int idx, tag;
        bit hit;
        idx = addr % NLINES;
        tag = addr / NLINES;
        hit = (m_state[idx] != ST_I) && (m_tag[idx] == tag);
        nmsg = 0;
        if (hit && we == 0) begin
            resp_q.push_back('{m_data[idx], 1, 2});
        end else if (hit && m_state[idx] == ST_M) begin
            m_data[idx] = wdata;
            resp_q.push_back('{wdata, 1, 2});
        end else begin
            if (!hit && m_state[idx] == ST_M) begin
                bus_q.push_back('{T_WB, m_tag[idx] * NLINES + idx, m_data[idx]});
                nmsg++;
            end
            if (we == 0) begin
                bus_q.push_back('{T_RDMISS, addr, 0});
                m_state[idx] = ST_S;
                m_data[idx]  = fill;
                resp_q.push_back('{fill, 0, -1});
            end else begin
                bus_q.push_back('{T_INVAL, addr, 0});
                m_state[idx] = ST_M;
                m_data[idx]  = wdata;
                resp_q.push_back('{wdata, 0, -1});
            end
            m_tag[idx] = tag;
            nmsg++;
        end
    endtask

    task automatic model_snoop(input int typ, input int addr, input int src, input int fcyc);
        int idx;
        idx = addr % NLINES;
        if (src != 0 && m_state[idx] != ST_I && m_tag[idx] == addr / NLINES) begin
            if (typ == T_RDMISS && m_state[idx] == ST_M) begin
                flush_q.push_back('{addr, m_data[idx], fcyc});
                m_state[idx] = ST_S;
            end else if (typ == T_INVAL) begin
                if (m_state[idx] == ST_M) flush_q.push_back('{addr, m_data[idx], fcyc});
                m_state[idx] = ST_I;
            end
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NLINES; i++) begin
            m_state[i] = ST_I; m_tag[i] = 0; m_data[i] = 0;
        end
    endtask

    task automatic drive_snoop(input int typ, input int addr, input int src);
        @(negedge clock);
        cc.snp_valid = 1'b1;
        cc.snp_type  = 2'(typ);
        cc.snp_addr  = 5'(addr);
        cc.snp_src   = 2'(src);
        model_snoop(typ, addr, src, cyc + 1);
        @(negedge clock);
        cc.snp_valid = 1'b0;
    endtask

    task automatic drive_req(input int we, input int addr, input int wdata);
        int t;
        @(negedge clock);
        t = 0;
        while (!cc.cpu_req_ready && t < 50) begin @(negedge clock); t++; end
        check("req_ready_idle", int'(cc.cpu_req_ready), 1);
        cc.cpu_req_valid = 1'b1;
        cc.cpu_req_we    = we[0];
        cc.cpu_req_addr  = 5'(addr);
        cc.cpu_req_wdata = 4'(wdata);
        acc_cyc = cyc;
        @(negedge clock);
        cc.cpu_req_valid = 1'b0;
        check("req_ready_busy", int'(cc.cpu_req_ready), 0);
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (resp_q.size() != 0 && t < 300) begin @(negedge clock); t++; end
        check("resp_timeout", resp_q.size(), 0);
        @(negedge clock);
        check("bus_msgs_left", bus_q.size(), 0);
    endtask

    task automatic wait_bus_req();
        int t;
        t = 0;
        while (!cc.bus_req && t < 30) begin @(negedge clock); t++; end
        check("bus_req_seen", int'(cc.bus_req), 1);
    endtask

    task automatic do_req(input int we, input int addr, input int wdata);
        int nmsg, g0, fill;
        fill = $urandom_range(0, 15);
        next_fill = 4'(fill);
        g0 = n_grants;
        model_req(we, addr, wdata, fill, nmsg);
        drive_req(we, addr, wdata);
        wait_done();
        check("grant_count", n_grants - g0, nmsg);
    endtask

    // Request held in arbitration while a foreign snoop hits the line, then released
    task automatic race_req(input int we, input int addr, input int wdata,
                            input int styp, input int saddr, input int ssrc, input int extra);
        int nmsg, g0;
        hold_gnt = 1'b1;
        g0 = n_grants;
        drive_req(we, addr, wdata);
        wait_bus_req();
        drive_snoop(styp, saddr, ssrc);
        model_req(we, addr, wdata, 0, nmsg);
        hold_gnt = 1'b0;
        wait_done();
        check("race_grant_count", n_grants - g0, nmsg + extra);
    endtask

    function automatic int rand_addr();
        return $urandom_range(0, 2) * NLINES + $urandom_range(0, NLINES - 1);
    endfunction

    // Arbiter: grants a pending request after a random delay unless held
    initial begin
        cc.bus_gnt = 1'b0;
        forever begin
            @(negedge clock);
            if (cc.bus_gnt) cc.bus_gnt = 1'b0;
            else if (cc.bus_req && !hold_gnt && $urandom_range(0, 2) == 0) begin
                cc.bus_gnt = 1'b1;
                n_grants++;
            end
        end
    end

    // Memory side: answers each RDMISS with a fill, plus requested stray fills while idle
    initial begin
        cc.fill_valid = 1'b0;
        cc.fill_data  = '0;
        forever begin
            @(negedge clock);
            cc.fill_valid = 1'b0;
            cc.fill_data  = '0;
            if (junk_req != junk_done) begin
                cc.fill_valid = 1'b1;
                cc.fill_data  = 4'($urandom_range(0, 15));
                junk_done++;
            end else if (cc.bus_out_valid && int'(cc.bus_out_type) == T_RDMISS) begin
                repeat (1 + $urandom_range(0, 2)) @(negedge clock);
                cc.fill_valid = 1'b1;
                cc.fill_data  = next_fill;
            end
        end
    end

    // Monitor: every DUT output event is matched against the head of its queue
    always @(negedge clock) begin
        resp_t r;
        msg_t m;
        flush_t f;
        if (!reset) begin
            if (cc.cpu_resp_valid) begin
                if (resp_q.size() == 0) check("resp_unexpected", 1, 0);
                else begin
                    r = resp_q.pop_front();
                    check("resp_rdata", int'(cc.cpu_resp_rdata), r.data);
                    check("resp_hit", int'(cc.cpu_resp_hit), r.hit);
                    if (r.lat >= 0) check("resp_latency", cyc - acc_cyc, r.lat);
                end
            end
            if (cc.bus_out_valid) begin
                if (bus_q.size() == 0) check("bus_unexpected", 1, 0);
                else begin
                    m = bus_q.pop_front();
                    check("bus_type", int'(cc.bus_out_type), m.typ);
                    check("bus_addr", int'(cc.bus_out_addr), m.addr);
                    check("bus_data", int'(cc.bus_out_data), m.data);
                end
            end
            if (cc.flush_valid) begin
                if (flush_q.size() == 0) check("flush_unexpected", 1, 0);
                else begin
                    f = flush_q.pop_front();
                    check("flush_addr", int'(cc.flush_addr), f.addr);
                    check("flush_data", int'(cc.flush_data), f.data);
                    check("flush_cycle", cyc, f.cyc);
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        cc.cpu_req_valid = 1'b0; cc.cpu_req_we = 1'b0; cc.cpu_req_addr = '0; cc.cpu_req_wdata = '0;
        cc.snp_valid = 1'b0; cc.snp_type = '0; cc.snp_addr = '0; cc.snp_src = '0;
        model_clear();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_ready", int'(cc.cpu_req_ready), 1);
        check("rst_resp_valid", int'(cc.cpu_resp_valid), 0);
        check("rst_bus_req", int'(cc.bus_req), 0);
        check("rst_bus_valid", int'(cc.bus_out_valid), 0);
        check("rst_flush", int'(cc.flush_valid), 0);

        // Directed sequence around line 1 (0x05 tag 1, 0x09 tag 2, 0x0D tag 3)
        do_req(0, 5'h05, 0);
        do_req(0, 5'h05, 0);
        do_req(1, 5'h05, 4'hA);
        do_req(0, 5'h05, 0);
        do_req(0, 5'h09, 0);
        do_req(1, 5'h05, 4'hA);
        drive_snoop(T_RDMISS, 5'h05, 1);
        do_req(1, 5'h05, 4'hA);
        race_req(1, 5'h09, 4'h7, T_INVAL, 5'h05, 1, 1);
        drive_snoop(T_INVAL, 5'h09, 0);
        drive_snoop(T_INVAL, 5'h0D, 2);
        do_req(0, 5'h09, 0);
        drive_snoop(T_RDMISS, 5'h09, 1);
        race_req(1, 5'h09, 4'hB, T_INVAL, 5'h09, 3, 0);
        do_req(0, 5'h09, 0);

        // Randomized requests interleaved with idle snoops and stray fills
        for (int n = 0; n < 200; n++) begin
            for (int s = $urandom_range(0, 2); s > 0; s--)
                drive_snoop($urandom_range(1, 3), rand_addr(), $urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                junk_req++;
                repeat (2) @(negedge clock);
            end
            do_req($urandom_range(0, 1), rand_addr(), $urandom_range(0, 15));
        end

        // Reset in the middle of a pending miss: nothing completes, contents are lost
        hold_gnt = 1'b1;
        drive_req(1, 5'h02, 4'h3);
        wait_bus_req();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("midrst_bus_req", int'(cc.bus_req), 0);
        check("midrst_resp", int'(cc.cpu_resp_valid), 0);
        reset = 1'b0;
        hold_gnt = 1'b0;
        model_clear();
        @(negedge clock);
        check("midrst_ready", int'(cc.cpu_req_ready), 1);
        do_req(0, 5'h09, 0);

        repeat (3) @(negedge clock);
        check("resp_q_empty", resp_q.size(), 0);
        check("flush_q_empty", flush_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
